// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell counter: J/K command encodings and default width.
`timescale 1ns/10ps
package jk_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // {J,K} command encodings applied to one JK cell
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset and complement output.
`timescale 1ns/10ps
module jk_cell
  import jk_pkg::*;
(
  input  logic reset,
  output logic q,
  output logic qb,
  input  logic j,
  input  logic k,
  input  logic clk
);

  logic q_q;
  logic q_d;

  // JK characteristic equation: hold, clear, set or toggle
  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_CLR:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // State register; reset clears the cell immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down modulo-(MAX+1) counter built from JK cells with
// parallel load. Only the J/K steering, load clamp and tc live here;
// all state is held in the jk_cell instances.
`timescale 1ns/10ps
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX   = 4'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] load_val;
  logic             q_at_max;
  logic             q_at_zero;
  logic             q_over_max;

  // Load values above the terminal value saturate at MAX
  assign load_val   = (d > MAX) ? MAX : d;
  assign q_at_max   = (q == MAX);
  assign q_at_zero  = (q == '0);
  assign q_over_max = (q > MAX);

  // Per-cell J/K steering: load beats count beats hold. Counting uses
  // ripple toggle terms; wrap and out-of-range recovery force all cells
  // to a fixed pattern (0 going up, MAX going down).
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [1:0] cmd;
    j_d    = '0;
    k_d    = '0;
    carry  = 1'b1;
    borrow = 1'b1;
    cmd    = JK_HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      cmd = JK_HOLD;
      if (load) begin
        cmd = load_val[i] ? JK_SET : JK_CLR;
      end else if (en) begin
        if (up) begin
          if (q_at_max || q_over_max) begin
            cmd = JK_CLR;
          end else begin
            cmd = carry ? JK_TGL : JK_HOLD;
          end
        end else begin
          if (q_at_zero || q_over_max) begin
            cmd = MAX[i] ? JK_SET : JK_CLR;
          end else begin
            cmd = borrow ? JK_TGL : JK_HOLD;
          end
        end
      end
      j_d[i] = cmd[1];
      k_d[i] = cmd[0];
      carry  = carry & q[i];
      borrow = borrow & ~q[i];
    end
  end

  // Terminal count is purely combinational, gated off by load
  assign tc = en & ~load & ((up & q_at_max) | (~up & q_at_zero));

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
        .reset (reset),
        .q     (q[g]),
        .qb    (qb[g]),
        .j     (j_d[g]),
        .k     (k_d[g]),
        .clk   (clk)
      );
    end
  endgenerate

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed and random stimulus for jk_sync_counter (WIDTH=4, MAX=9) with an
// arithmetic reference model feeding an expected-value queue.
`timescale 1ns/10ps
module tb_jk_sync_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] qb;
  logic       tc;

  int         checks;
  int         errors;
  logic [3:0] m_q;
  logic [3:0] exp_q[$];

  jk_sync_counter dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (d),
    .q     (q),
    .qb    (qb),
    .tc    (tc)
  );

  // Clock: period 2, posedges at even times
  initial begin
    clk = 1'b1;
    forever #1 clk = ~clk;
  end

  // Watchdog
  initial begin
    #5000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] m, input logic rst,
                                            input logic e, input logic u,
                                            input logic l, input logic [3:0] dv);
    if (rst)    return 4'd0;
    if (l)      return (dv > 4'd9) ? 4'd9 : dv;
    if (!e)     return m;
    if (u)      return (m >= 4'd9) ? 4'd0 : m + 4'd1;
    return (m == 4'd0 || m > 4'd9) ? 4'd9 : m - 4'd1;
  endfunction

  function automatic logic model_tc(input logic [3:0] m, input logic e,
                                    input logic u, input logic l);
    return e & ~l & ((u & (m == 4'd9)) | (~u & (m == 4'd0)));
  endfunction

  // Drive one control set at the falling edge, check tc, then check q after the rising edge
  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] dv);
    @(negedge clk);
    en = e; up = u; load = l; d = dv;
    #0.5;
    check("tc", {3'b0, tc}, {3'b0, model_tc(m_q, e, u, l)});
    exp_q.push_back(model_next(m_q, reset, e, u, l, dv));
    m_q = model_next(m_q, reset, e, u, l, dv);
    @(posedge clk);
    #0.5;
    check("q", q, exp_q.pop_front());
  endtask

  // Complement output checked every half cycle
  always @(clk) begin
    #0.5;
    check("qb", qb, ~q);
  end

  initial begin
    checks = 0;
    errors = 0;
    m_q    = 4'd0;
    reset  = 1'b1;
    en     = 1'b0;
    up     = 1'b0;
    load   = 1'b0;
    d      = 4'd0;
    fork
      begin #5 reset = 1'b0; end
    join_none

    #0.5;
    check("reset_q", q, 4'd0);
    check("reset_qb", qb, 4'hf);
    check("reset_tc", {3'b0, tc}, 4'd0);

    // During reset: load and count ignored, tc still follows q=0
    step(1'b1, 1'b0, 1'b1, 4'd5);
    step(1'b1, 1'b0, 1'b0, 4'd0);

    // Count up 0..9 and wrap to 0
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
    // Count down from 0: 9..0 and wrap to 9
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 4'd0);

    // Load wins over count, then clamp of oversize load
    step(1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b1, 1'b1, 1'b1, 4'd7);
    step(1'b1, 1'b1, 1'b1, 4'd14);
    step(1'b0, 1'b0, 1'b1, 4'd15);

    // Hold with direction toggling
    step(1'b0, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 4; i++) step(1'b0, i[0], 1'b0, 4'd0);

    // Direction change while enabled, from the middle of the range
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);

    // Reset pulse between edges while counting up from 6
    step(1'b0, 1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    reset = 1'b1;
    #0.25;
    check("pulse_q", q, 4'd0);
    check("pulse_qb", qb, 4'hf);
    check("pulse_tc", {3'b0, tc}, 4'd0);
    #0.75;
    reset = 1'b0;
    m_q = 4'd0;
    exp_q.push_back(model_next(m_q, 1'b0, en, up, load, d));
    m_q = model_next(m_q, 1'b0, en, up, load, d);
    @(posedge clk);
    #0.5;
    check("post_pulse_q", q, exp_q.pop_front());

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
    end

    check("queue_empty", 4'(exp_q.size()), 4'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter bit width.
REQ-002 Parameter MAX, default 4'd9, terminal value; legal range 1 .. 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 q  output  WIDTH  counter state, taken directly from JK cell outputs.
REQ-010 qb  output  WIDTH  bitwise complement of q, taken from JK cell complement outputs.
REQ-011 tc  output  1  terminal-count flag, combinational.

Function
REQ-012 Every state bit SHALL be a JK flip-flop cell; next state per cell: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
REQ-013 Cell J/K inputs SHALL be derived combinationally from q, en, up, load and d; no other storage SHALL exist.
REQ-014 Priority per edge: load over en over hold.
REQ-015 load=1: q SHALL take d on the edge (J=d[i], K=~d[i]); d > MAX SHALL load MAX.
REQ-016 load=0, en=0: all cells J=K=0; q SHALL hold.
REQ-017 en=1, up=1, q<MAX: q SHALL become q+1 via ripple-carry toggle terms (bit i toggles when bits 0..i-1 are all 1).
REQ-018 en=1, up=1, q==MAX: q SHALL become 0 on the edge.
REQ-019 en=1, up=0, q>0: q SHALL become q-1 (bit i toggles when bits 0..i-1 are all 0).
REQ-020 en=1, up=0, q==0: q SHALL become MAX on the edge.
REQ-021 Out-of-range state (q>MAX, reachable only by fault) SHALL return to 0 on the next enabled up edge and to MAX on the next enabled down edge.
REQ-022 tc SHALL equal en & ~load & ((up & q==MAX) | (~up & q==0)).
REQ-023 Latency: q SHALL reflect load/count one clk edge after the control sample; tc has zero latency.
REQ-024 up change while en=1 SHALL take effect on the same edge it is sampled.
REQ-025 qb SHALL equal ~q at all times, including during reset.

Reset
REQ-026 reset=1 SHALL force q=0 and qb=all ones immediately, independent of clk.
REQ-027 While reset=1, load and en SHALL be ignored; tc SHALL follow REQ-022 with q=0.
REQ-028 Reset deasserted between edges: the first rising edge after deassertion SHALL operate normally from q=0.
REQ-029 Reset asserted mid-count SHALL abort the count; no partial update SHALL survive.

Structure
REQ-030 Shared package jk_pkg SHALL hold the JK command constants JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11 and the default WIDTH.
REQ-031 One sub-module jk_cell (ports reset, q, qb, j, k, clk, same order) SHALL be instantiated WIDTH times through a generate loop.
REQ-032 jk_sync_counter SHALL contain only combinational J/K steering, clamp and tc logic around the cells.

Verification
REQ-033 Bench clk period 2 time units; reset=1 for 5 units, then 0; en=1, up=1 -> q sequence 0,1,...,9,0; tc=1 only while q=9.
REQ-034 en=1, up=0 from q=0 -> q=9,8,...,0,9; tc=1 only while q=0.
REQ-035 q=3, load=1, d=7, en=1 -> next q=7 (load wins); then load=1, d=14 -> q=9 (clamp).
REQ-036 q=5, en=0 for 4 edges, up toggling -> q stays 5, tc=0 throughout.
REQ-037 q=6 counting up; reset pulsed high for 1 unit between edges -> q=0 immediately, next enabled edge q=1.
REQ-038 All scenarios: qb == ~q checked every half cycle; waveform dumped to jk_sync_counter.vcd.
